// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-client AXI read arbiter.
// Holds the FSM state encoding, the burst type and the error cause codes.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_EARLY_LAST   = 2'b01;
    localparam logic [1:0] ERR_MISSING_LAST = 2'b10;
    localparam logic [1:0] ERR_RID          = 2'b11;

    // Full-width beats only: bytes per beat = DATA_WIDTH/8, encoded as log2.
    function automatic logic [2:0] arsize_for(input int data_width);
        logic [2:0] size;
        size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant from a request pair, with the
// priority pointer moving to the other client when a granted burst completes.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic [1:0] grant
);

    logic ptr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else if (done) begin
            ptr_reg <= ~done_idx;
        end
    end

    // The pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant = 2'b00;
        if (req[0] && req[1]) begin
            grant[ptr_reg] = 1'b1;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter_2x1.sv
// Shares one AXI4 read master port between two burst clients, one burst at a
// time, with burst-length and RID checking on the returned R beats.
module axi_rd_arbiter_2x1
    import axi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] c0_araddr,
    input  logic [7:0]            c0_arlen,
    input  logic                  c0_arvalid,
    output logic                  c0_arready,
    output logic [DATA_WIDTH-1:0] c0_rdata,
    output logic [1:0]            c0_rresp,
    output logic                  c0_rlast,
    output logic                  c0_rvalid,
    input  logic                  c0_rready,
    input  logic [ADDR_WIDTH-1:0] c1_araddr,
    input  logic [7:0]            c1_arlen,
    input  logic                  c1_arvalid,
    output logic                  c1_arready,
    output logic [DATA_WIDTH-1:0] c1_rdata,
    output logic [1:0]            c1_rresp,
    output logic                  c1_rlast,
    output logic                  c1_rvalid,
    input  logic                  c1_rready,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [ID_WIDTH-1:0]   m_rid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  err,
    output logic [1:0]            err_code
);

    arb_state_t            state_reg;
    logic                  gnt_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [7:0]            beat_cnt_reg;
    logic                  arvalid_reg;
    logic                  err_reg;
    logic [1:0]            err_code_reg;

    logic       in_idle;
    logic       in_data;
    logic [1:0] req;
    logic [1:0] grant;
    logic       gnt_rready;
    logic       r_hs;
    logic       r_done;
    logic [1:0] err_now;

    // Combinational handshakes are masked during reset so nothing leaks out.
    assign in_idle = (state_reg == IDLE) && !rst;
    assign in_data = (state_reg == DATA) && !rst;
    assign req     = in_idle ? {c1_arvalid, c0_arvalid} : 2'b00;

    rr_arbiter_2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (r_done),
        .done_idx (gnt_reg),
        .grant    (grant)
    );

    assign c0_arready = grant[0];
    assign c1_arready = grant[1];

    assign gnt_rready = gnt_reg ? c1_rready : c0_rready;
    assign m_rready   = in_data && gnt_rready;
    assign c0_rvalid  = in_data && !gnt_reg && m_rvalid;
    assign c1_rvalid  = in_data &&  gnt_reg && m_rvalid;
    assign r_hs       = in_data && m_rvalid && gnt_rready;
    assign r_done     = r_hs && m_rlast;

    assign c0_rdata = m_rdata;
    assign c1_rdata = m_rdata;
    assign c0_rresp = m_rresp;
    assign c1_rresp = m_rresp;
    assign c0_rlast = m_rlast;
    assign c1_rlast = m_rlast;

    assign m_arid    = ID_WIDTH'(gnt_reg);
    assign m_araddr  = addr_reg;
    assign m_arlen   = len_reg;
    assign m_arsize  = arsize_for(DATA_WIDTH);
    assign m_arburst = AXI_BURST_INCR;
    assign m_arvalid = arvalid_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

    // Beat counter holds the index of the beat currently on the bus.
    always_comb begin
        err_now = ERR_NONE;
        if (m_rlast && (beat_cnt_reg != len_reg)) begin
            err_now = ERR_EARLY_LAST;
        end else if (!m_rlast && (beat_cnt_reg == len_reg)) begin
            err_now = ERR_MISSING_LAST;
        end else if (m_rid != ID_WIDTH'(gnt_reg)) begin
            err_now = ERR_RID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= 1'b0;
            addr_reg     <= '0;
            len_reg      <= '0;
            beat_cnt_reg <= '0;
            arvalid_reg  <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|grant) begin
                        addr_reg    <= grant[1] ? c1_araddr : c0_araddr;
                        len_reg     <= grant[1] ? c1_arlen  : c0_arlen;
                        gnt_reg     <= grant[1];
                        arvalid_reg <= 1'b1;
                        state_reg   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        arvalid_reg  <= 1'b0;
                        beat_cnt_reg <= '0;
                        state_reg    <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        // First error wins and sticks; the burst still runs to rlast.
                        if (!err_reg && (err_now != ERR_NONE)) begin
                            err_reg      <= 1'b1;
                            err_code_reg <= err_now;
                        end
                        if (m_rlast) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Randomised bench for axi_rd_arbiter_2x1: client and slave drivers, a
// transaction-level reference model checked every cycle, and directed pins.
`timescale 1ns/1ps
module tb_axi_rd_arbiter_2x1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] c_araddr  [2];
    logic [7:0]    c_arlen   [2];
    logic          c_arvalid [2];
    logic          c_arready [2];
    logic [DW-1:0] c_rdata   [2];
    logic [1:0]    c_rresp   [2];
    logic          c_rlast   [2];
    logic          c_rvalid  [2];
    logic          c_rready  [2];

    logic [IW-1:0] m_arid;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [IW-1:0] m_rid;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic          err;
    logic [1:0]    err_code;

    axi_rd_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .c0_araddr(c_araddr[0]), .c0_arlen(c_arlen[0]), .c0_arvalid(c_arvalid[0]),
        .c0_arready(c_arready[0]), .c0_rdata(c_rdata[0]), .c0_rresp(c_rresp[0]),
        .c0_rlast(c_rlast[0]), .c0_rvalid(c_rvalid[0]), .c0_rready(c_rready[0]),
        .c1_araddr(c_araddr[1]), .c1_arlen(c_arlen[1]), .c1_arvalid(c_arvalid[1]),
        .c1_arready(c_arready[1]), .c1_rdata(c_rdata[1]), .c1_rresp(c_rresp[1]),
        .c1_rlast(c_rlast[1]), .c1_rvalid(c_rvalid[1]), .c1_rready(c_rready[1]),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err(err), .err_code(err_code)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Stimulus controls
    int gap_pct = 0, rready_pct = 100, rvalid_pct = 100, ar_mode = 0;
    int early_at = -1;
    bit bad_rid = 0, rlast_chk = 1, chk_en = 0;

    req_t pend_q [2][$];
    req_t out_q  [2][$];
    int   rx_idx [2];
    int   beats_rx [2];
    int   grant_log [$];
    int   arid_log [$];

    // Handshakes observed at the previous falling edge
    bit ar_hs_f [2];
    bit m_ar_hs_f, m_r_hs_f, rst_f;

    // Reference model state
    bit         busy = 0, ar_out = 0;
    int         own = 0, ptr = 0;
    logic [31:0] b_addr = '0;
    logic [7:0]  b_len = '0, seen = '0;
    bit         merr = 0;
    logic [1:0] mcode = '0;

    // Slave state
    bit          sl_have = 0;
    logic [31:0] sl_addr;
    int          sl_len, sl_beat;
    logic [IW-1:0] sl_id;

    // Client drivers
    initial begin
        for (int x = 0; x < 2; x++) begin
            c_araddr[x] = '0; c_arlen[x] = '0; c_arvalid[x] = 1'b0; c_rready[x] = 1'b0;
        end
        forever begin
            @(posedge clk); #1;
            for (int x = 0; x < 2; x++) begin
                if (ar_hs_f[x]) c_arvalid[x] = 1'b0;
                if (!c_arvalid[x] && pend_q[x].size() > 0 && $urandom_range(99) >= gap_pct) begin
                    c_araddr[x]  = pend_q[x][0].addr;
                    c_arlen[x]   = pend_q[x][0].len;
                    c_arvalid[x] = 1'b1;
                    void'(pend_q[x].pop_front());
                end
                c_rready[x] = ($urandom_range(99) < rready_pct);
            end
        end
    end

    // Slave driver: returns addr + 4*beat, honouring the fault knobs
    initial begin
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_f) begin
                sl_have = 0; m_rvalid = 1'b0; m_rlast = 1'b0;
            end else begin
                if (m_ar_hs_f) begin
                    sl_have = 1; sl_addr = m_araddr; sl_len = int'(m_arlen); sl_id = m_arid; sl_beat = 0;
                end
                if (m_r_hs_f) begin
                    if (m_rlast) sl_have = 0;
                    else sl_beat++;
                    m_rvalid = 1'b0;
                end
                if (sl_have && !m_rvalid && $urandom_range(99) < rvalid_pct) begin
                    m_rvalid = 1'b1;
                    m_rdata  = sl_addr + 32'(sl_beat * 4);
                    m_rresp  = 2'(sl_beat);
                    m_rid    = sl_id ^ IW'(bad_rid);
                    m_rlast  = (early_at >= 0) ? (sl_beat == early_at) : (sl_beat == sl_len);
                end
            end
            case (ar_mode)
                0: m_arready = 1'b1;
                1: m_arready = ($urandom_range(99) < 50);
                default: m_arready = 1'b0;
            endcase
        end
    end

    // Monitor, per-cycle comparison against the model, and model advance
    always @(negedge clk) begin
        int win;
        logic [1:0] code;
        bit exp_arv;
        win = -1;
        if (!rst && !busy) begin
            if (c_arvalid[0] && c_arvalid[1]) win = ptr;
            else if (c_arvalid[0]) win = 0;
            else if (c_arvalid[1]) win = 1;
        end
        exp_arv = busy && !ar_out;
        if (chk_en) begin
            for (int x = 0; x < 2; x++) begin
                chk($sformatf("c%0d_arready", x), c_arready[x], (win == x));
                chk($sformatf("c%0d_rvalid", x), c_rvalid[x],
                    !rst && busy && ar_out && own == x && m_rvalid);
                chk($sformatf("c%0d_rdata", x), c_rdata[x], m_rdata);
                chk($sformatf("c%0d_rresp", x), c_rresp[x], m_rresp);
                chk($sformatf("c%0d_rlast", x), c_rlast[x], m_rlast);
            end
            chk("m_arvalid", m_arvalid, exp_arv);
            if (exp_arv) begin
                chk("m_araddr", m_araddr, b_addr);
                chk("m_arlen", m_arlen, b_len);
                chk("m_arid", m_arid, own);
            end
            chk("m_rready", m_rready, !rst && busy && ar_out && c_rready[own]);
            chk("m_arsize", m_arsize, 3'd2);
            chk("m_arburst", m_arburst, 2'b01);
            chk("err", err, merr);
            chk("err_code", err_code, mcode);
        end

        // Client-side ordering scoreboard
        for (int x = 0; x < 2; x++) begin
            ar_hs_f[x] = c_arvalid[x] && c_arready[x];
            if (ar_hs_f[x]) begin
                out_q[x].push_back('{addr: c_araddr[x], len: c_arlen[x]});
                grant_log.push_back(x);
            end
            if (c_rvalid[x] && c_rready[x]) begin
                beats_rx[x]++;
                if (out_q[x].size() == 0) begin
                    chk($sformatf("c%0d_r_unexpected", x), c_rvalid[x], 1'b0);
                end else begin
                    chk($sformatf("c%0d_beat_data", x), c_rdata[x], out_q[x][0].addr + 32'(rx_idx[x] * 4));
                    if (rlast_chk)
                        chk($sformatf("c%0d_beat_last", x), c_rlast[x], rx_idx[x] == int'(out_q[x][0].len));
                    rx_idx[x]++;
                    if (c_rlast[x]) begin
                        void'(out_q[x].pop_front());
                        rx_idx[x] = 0;
                    end
                end
            end
        end
        m_ar_hs_f = m_arvalid && m_arready;
        m_r_hs_f  = m_rvalid && m_rready;
        rst_f     = rst;
        if (m_ar_hs_f) arid_log.push_back(int'(m_arid));

        if (rst) begin
            busy = 0; ar_out = 0; ptr = 0; merr = 0; mcode = '0; own = 0;
            for (int x = 0; x < 2; x++) begin
                out_q[x].delete(); rx_idx[x] = 0;
            end
        end else if (!busy) begin
            if (win >= 0) begin
                busy = 1; ar_out = 0; own = win;
                b_addr = c_araddr[win]; b_len = c_arlen[win];
            end
        end else if (!ar_out) begin
            if (m_arready) begin
                ar_out = 1; seen = '0;
            end
        end else if (m_rvalid && c_rready[own]) begin
            code = 2'b00;
            if (m_rlast && seen != b_len) code = 2'b01;
            else if (!m_rlast && seen == b_len) code = 2'b10;
            else if (int'(m_rid) != own) code = 2'b11;
            if (!merr && code != 2'b00) begin
                merr = 1; mcode = code;
            end
            seen = seen + 8'd1;
            if (m_rlast) begin
                busy = 0; ptr = 1 - own;
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #3;
            if (!busy && pend_q[0].size() == 0 && pend_q[1].size() == 0 &&
                !c_arvalid[0] && !c_arvalid[1]) break;
            n++;
            if (n >= budget) begin
                timeout(name);
                break;
            end
        end
    endtask

    initial begin
        int base0, base1, n, exp0, exp1;
        bit found;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk_en = 1;
        do_reset(2);

        // 1: single c0 burst, immediate m_arready
        @(negedge clk);
        chk("t0_reset_m_arvalid", m_arvalid, 1'b0);
        chk("t0_reset_err", err, 1'b0);
        base0 = beats_rx[0]; base1 = beats_rx[1];
        pend_q[0].push_back('{addr: 32'h1000, len: 8'd3});
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (c_arready[0]) found = 1;
        end
        if (!found) timeout("t1_arready");
        else begin
            chk("t1_arvalid_same_cycle", c_arvalid[0], 1'b1);
            chk("t1_m_arvalid_before", m_arvalid, 1'b0);
            @(negedge clk);
            chk("t1_m_arvalid", m_arvalid, 1'b1);
            chk("t1_m_arid", m_arid, 8'd0);
            chk("t1_m_araddr", m_araddr, 32'h1000);
            chk("t1_m_arlen", m_arlen, 8'd3);
        end
        wait_quiet(200, "t1_done");
        chk("t1_c0_beats", beats_rx[0] - base0, 4);
        chk("t1_c1_beats", beats_rx[1] - base1, 0);
        chk("t1_err", err, 1'b0);

        // 2: tied requests alternate
        do_reset(2);
        grant_log.delete(); arid_log.delete();
        @(negedge clk);
        pend_q[0].push_back('{addr: 32'h2000, len: 8'd1});
        pend_q[0].push_back('{addr: 32'h2100, len: 8'd2});
        pend_q[1].push_back('{addr: 32'h3000, len: 8'd2});
        pend_q[1].push_back('{addr: 32'h3100, len: 8'd0});
        wait_quiet(400, "t2_done");
        chk("t2_grant_count", grant_log.size(), 4);
        chk("t2_arid_count", arid_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size() && i < arid_log.size(); i++) begin
            chk($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
            chk($sformatf("t2_arid%0d", i), arid_log[i], i % 2);
        end

        // 3: m_arready held low
        ar_mode = 2;
        @(negedge clk);
        pend_q[0].push_back('{addr: 32'h4000, len: 8'd2});
        pend_q[1].push_back('{addr: 32'h5000, len: 8'd1});
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_arvalid) found = 1;
        end
        if (!found) timeout("t3_arvalid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_arvalid", m_arvalid, 1'b1);
            chk("t3_hold_araddr", m_araddr, 32'h4000);
            chk("t3_hold_arlen", m_arlen, 8'd2);
            chk("t3_c0_arready", c_arready[0], 1'b0);
            chk("t3_c1_arready", c_arready[1], 1'b0);
        end
        ar_mode = 0;
        wait_quiet(400, "t3_done");

        // 4: early rlast, then an RID error that must not overwrite the code
        early_at = 2; rlast_chk = 0;
        @(negedge clk);
        pend_q[0].push_back('{addr: 32'h6000, len: 8'd3});
        wait_quiet(200, "t4_done");
        @(negedge clk);
        chk("t4_err", err, 1'b1);
        chk("t4_err_code", err_code, 2'b01);
        chk("t4_idle_m_rready", m_rready, 1'b0);
        early_at = -1; rlast_chk = 1; bad_rid = 1;
        pend_q[1].push_back('{addr: 32'h7000, len: 8'd1});
        wait_quiet(200, "t4b_done");
        @(negedge clk);
        chk("t4_err_code_sticky", err_code, 2'b01);
        bad_rid = 0;

        // 5: reset in the middle of c1's len-7 burst
        base1 = beats_rx[1];
        @(negedge clk);
        pend_q[1].push_back('{addr: 32'h8000, len: 8'd7});
        n = 0;
        forever begin
            @(posedge clk); #3;
            if (beats_rx[1] - base1 >= 2) break;
            n++;
            if (n >= 200) begin timeout("t5_beats"); break; end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_m_arvalid", m_arvalid, 1'b0);
        chk("t5_m_araddr", m_araddr, 32'h0);
        chk("t5_m_arlen", m_arlen, 8'd0);
        chk("t5_m_arid", m_arid, 8'd0);
        chk("t5_err", err, 1'b0);
        chk("t5_err_code", err_code, 2'b00);
        chk("t5_c0_rvalid", c_rvalid[0], 1'b0);
        chk("t5_c1_rvalid", c_rvalid[1], 1'b0);
        chk("t5_c0_arready", c_arready[0], 1'b0);
        chk("t5_c1_arready", c_arready[1], 1'b0);
        chk("t5_m_rready", m_rready, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        grant_log.delete();
        @(negedge clk);
        pend_q[0].push_back('{addr: 32'h9000, len: 8'd0});
        pend_q[1].push_back('{addr: 32'hA000, len: 8'd0});
        wait_quiet(200, "t5_done");
        chk("t5_grant_count", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            chk("t5_first_grant", grant_log[0], 0);
            chk("t5_second_grant", grant_log[1], 1);
        end

        // 6: random traffic with two len-255 bursts and backpressure everywhere
        gap_pct = 30; rready_pct = 60; rvalid_pct = 70; ar_mode = 1;
        base0 = beats_rx[0]; base1 = beats_rx[1];
        @(negedge clk);
        pend_q[0].push_back('{addr: 32'hB000, len: 8'd255});
        pend_q[1].push_back('{addr: 32'hC000, len: 8'd255});
        exp0 = 256; exp1 = 256;
        for (int i = 0; i < 10; i++) begin
            for (int x = 0; x < 2; x++) begin
                req_t r;
                r.addr = $urandom & 32'hFFFF_FFF0;
                r.len  = 8'($urandom_range(0, 15));
                pend_q[x].push_back(r);
                if (x == 0) exp0 += int'(r.len) + 1;
                else exp1 += int'(r.len) + 1;
            end
        end
        wait_quiet(30000, "t6_done");
        chk("t6_c0_beats", beats_rx[0] - base0, exp0);
        chk("t6_c1_beats", beats_rx[1] - base1, exp1);
        chk("t6_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
